// File: rtl/acc_arb.sv
// acc_arb: round-robin request arbiter and single-outstanding sequencer for
// the shared top_acc 4-lane 8x8 multiply datapath.
//
// Ports:
//   HCLK, HRESET          clock, asynchronous active-high reset
//   req_valid_i/ready_o   per-requester request handshake (bit k = requester k)
//   req_a_i, req_b_i      per-requester operands, lane j = bits [8j+7:8j]
//   rsp_valid_o/ready_i   per-requester response handshake
//   rsp_data_o            held 64-bit result, lane j = bits [16j+15:16j]
//   acc_in_A_o/B_o        registered operands driven to top_acc
//   acc_out_i             product lanes returned by top_acc
//   busy_o                high whenever the sequencer is not idle
//   op_count_o            completed response handshakes, wraps at 16 bits
module acc_arb #(
  parameter int ACC_LAT = 1
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0][31:0] req_a_i,
  input  logic [1:0][31:0] req_b_i,
  output logic [1:0]       rsp_valid_o,
  input  logic [1:0]       rsp_ready_i,
  output logic [63:0]      rsp_data_o,
  output logic [3:0][7:0]  acc_in_A_o,
  output logic [3:0][7:0]  acc_in_B_o,
  input  logic [3:0][15:0] acc_out_i,
  output logic             busy_o,
  output logic [15:0]      op_count_o
);

  localparam logic [3:0] LAT_C = 4'(ACC_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            gnt_id_q, gnt_id_d;
  logic            ptr_q, ptr_d;
  logic [3:0][7:0] a_q, a_d;
  logic [3:0][7:0] b_q, b_d;
  logic [63:0]     rsp_q, rsp_d;
  logic [15:0]     op_cnt_q, op_cnt_d;

  logic            gnt;
  logic            any_req;

  // With both requesters pending the pointer decides; with only one pending
  // that one wins. When none is pending the value is unused.
  assign any_req = |req_valid_i;
  assign gnt     = (req_valid_i == 2'b11) ? ptr_q : req_valid_i[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_id_d    = gnt_id_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_d       = rsp_q;
    op_cnt_d    = op_cnt_q;
    req_ready_o = 2'b00;
    rsp_valid_o = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        // Ready is suppressed while reset is asserted even though the
        // state register already reads IDLE.
        if (any_req && !HRESET) begin
          req_ready_o[gnt] = 1'b1;
          a_d              = req_a_i[gnt];
          b_d              = req_b_i[gnt];
          gnt_id_d         = gnt;
          cnt_d            = LAT_C;
          state_d          = S_WAIT;
        end
      end

      S_WAIT: begin
        // cnt counts down the accelerator latency; the capture happens on
        // the edge where it is already zero.
        if (cnt_q == 4'd0) begin
          rsp_d   = acc_out_i;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RESP: begin
        rsp_valid_o[gnt_id_q] = 1'b1;
        if (rsp_ready_i[gnt_id_q]) begin
          op_cnt_d = op_cnt_q + 16'd1;
          ptr_d    = ~gnt_id_q;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      gnt_id_q <= 1'b0;
      ptr_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rsp_q    <= 64'd0;
      op_cnt_q <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rsp_q    <= rsp_d;
      op_cnt_q <= op_cnt_d;
    end
  end

  assign acc_in_A_o = a_q;
  assign acc_in_B_o = b_q;
  assign rsp_data_o = rsp_q;
  assign busy_o     = (state_q != S_IDLE);
  assign op_count_o = op_cnt_q;

endmodule
